// File: rtl/tx_ampl_ramp.sv
// rtl/tx_ampl_ramp.sv - TX burst amplitude ramp shaper (4-state gain FSM + 2-stage I/Q gain multiply)
// Optional: define TX_RAMP_SAT_EN to saturate the scaled output instead of wrapping.
module tx_ampl_ramp #(
    parameter int W  = 16,
    parameter int GW = 16
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic          tx_en,
    input  logic [W-1:0]  sig_i,
    input  logic [W-1:0]  sig_q,
    input  logic [GW-1:0] gain,
    input  logic [GW-1:0] ramp_step,
    output logic [W-1:0]  out_i,
    output logic [W-1:0]  out_q,
    output logic          out_valid,
    output logic [1:0]    state,
    output logic          burst_done
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_HOLD      = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    localparam int PW = W + GW + 1;

    state_t          r_state;
    logic [GW-1:0]   r_gain_cur;
    logic [GW-1:0]   r_gain_lat;
    logic            r_burst_done;

    logic [W-1:0]    r_s1_i;
    logic [W-1:0]    r_s1_q;
    logic [GW-1:0]   r_s1_g;
    logic            r_s1_v;

    logic [GW-1:0]   w_step_eff;
    logic [GW:0]     w_up_sum;
    logic [GW-1:0]   w_up_next;
    logic [GW-1:0]   w_dn_next;
    logic signed [PW-1:0] w_prod_i;
    logic signed [PW-1:0] w_prod_q;
    logic [W-1:0]    w_red_i;
    logic [W-1:0]    w_red_q;

    assign state      = r_state;
    assign burst_done = r_burst_done;

    // A zero step would stall a ramp forever, so it is promoted to 1 LSB.
    assign w_step_eff = (ramp_step == '0) ? {{(GW-1){1'b0}}, 1'b1} : ramp_step;

    // Up-step is computed one bit wider so gain_cur + step cannot wrap past gain_lat.
    assign w_up_sum  = {1'b0, r_gain_cur} + {1'b0, w_step_eff};
    assign w_up_next = (w_up_sum >= {1'b0, r_gain_lat}) ? r_gain_lat : w_up_sum[GW-1:0];
    assign w_dn_next = (r_gain_cur > w_step_eff) ? (r_gain_cur - w_step_eff) : '0;

    // Gain envelope FSM; tx_en changes take priority over the ramp step in both ramp states.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= S_IDLE;
            r_gain_cur   <= '0;
            r_gain_lat   <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_burst_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_gain_cur <= '0;
                    if (tx_en) begin
                        r_gain_lat <= gain;
                        r_state    <= S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (!tx_en) begin
                        r_state <= S_RAMP_DOWN;
                    end else begin
                        r_gain_cur <= w_up_next;
                        if (w_up_next == r_gain_lat) begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!tx_en) begin
                        r_state <= S_RAMP_DOWN;
                    end
                end
                S_RAMP_DOWN: begin
                    if (tx_en) begin
                        r_state <= S_RAMP_UP;
                    end else begin
                        r_gain_cur <= w_dn_next;
                        if (w_dn_next == '0) begin
                            r_state      <= S_IDLE;
                            r_burst_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1: align each sample with the gain value and burst flag present on the same edge.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_s1_i <= '0;
            r_s1_q <= '0;
            r_s1_g <= '0;
            r_s1_v <= 1'b0;
        end else begin
            r_s1_i <= sig_i;
            r_s1_q <= sig_q;
            r_s1_g <= r_gain_cur;
            r_s1_v <= (r_state != S_IDLE);
        end
    end

    // Signed sample times unsigned Q2.14 gain; both operands widened to the full product width.
    assign w_prod_i = $signed({{(GW+1){r_s1_i[W-1]}}, r_s1_i}) * $signed({{(W+1){1'b0}}, r_s1_g});
    assign w_prod_q = $signed({{(GW+1){r_s1_q[W-1]}}, r_s1_q}) * $signed({{(W+1){1'b0}}, r_s1_g});

`ifdef TX_RAMP_SAT_EN
    logic w_unused_frac;
    assign w_unused_frac = ^{w_prod_i[13:0], w_prod_q[13:0]};

    // Clamp when the bits above the output sign bit disagree with the product sign.
    assign w_red_i = (w_prod_i[PW-1:W+13] == {(GW-12){w_prod_i[PW-1]}}) ? w_prod_i[W+13:14] :
                     (w_prod_i[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
    assign w_red_q = (w_prod_q[PW-1:W+13] == {(GW-12){w_prod_q[PW-1]}}) ? w_prod_q[W+13:14] :
                     (w_prod_q[PW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{w_prod_i[13:0], w_prod_q[13:0], w_prod_i[PW-1:W+14], w_prod_q[PW-1:W+14]};

    // Arithmetic shift by 14 then keep the low W bits: two's-complement wrap on overflow.
    assign w_red_i = w_prod_i[W+13:14];
    assign w_red_q = w_prod_q[W+13:14];
`endif

    // Stage 2: register the reduced products and the delayed burst flag.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_i     <= w_red_i;
            out_q     <= w_red_q;
            out_valid <= r_s1_v;
        end
    end

endmodule

// File: tb/tb_tx_ampl_ramp.sv
// tb/tb_tx_ampl_ramp.sv - directed self-checking bench for tx_ampl_ramp
module tb_tx_ampl_ramp;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        tx_en;
    logic [15:0] sig_i;
    logic [15:0] sig_q;
    logic [15:0] gain;
    logic [15:0] ramp_step;
    logic [15:0] out_i;
    logic [15:0] out_q;
    logic        out_valid;
    logic [1:0]  state;
    logic        burst_done;

    int n_pass  = 0;
    int n_total = 0;

    // Ramp-up from IDLE: gain 0x4000, step 0x1000, I=0x1000, Q=0xF000
    localparam logic [1:0]  UP_ST [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    localparam logic [15:0] UP_OI [7] = '{16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0800, 16'h0C00, 16'h1000};
    localparam logic [15:0] UP_OQ [7] = '{16'h0000, 16'h0000, 16'h0000, 16'hFC00, 16'hF800, 16'hF400, 16'hF000};
    localparam logic        UP_OV [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Ramp-down from HOLD at 0x4000
    localparam logic [1:0]  DN_ST [7] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0};
    localparam logic [15:0] DN_OI [7] = '{16'h1000, 16'h1000, 16'h1000, 16'h0C00, 16'h0800, 16'h0400, 16'h0000};
    localparam logic        DN_BD [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic        DN_OV [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reversal: tx_en low for two edges once gain_cur reaches 0x2000
    localparam logic        RV_TX [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam logic [1:0]  RV_ST [11] = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    localparam logic [15:0] RV_OI [11] = '{16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0800, 16'h0800,
                                           16'h0400, 16'h0400, 16'h0800, 16'h0C00, 16'h1000};

    tx_ampl_ramp #(.W(16), .GW(16)) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .tx_en      (tx_en),
        .sig_i      (sig_i),
        .sig_q      (sig_q),
        .gain       (gain),
        .ramp_step  (ramp_step),
        .out_i      (out_i),
        .out_q      (out_q),
        .out_valid  (out_valid),
        .state      (state),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_b   = 1'b0;
        tx_en     = 1'b0;
        sig_i     = 16'h0000;
        sig_q     = 16'h0000;
        gain      = 16'h0000;
        ramp_step = 16'h0000;

        // Reset held, then released with tx_en low and random I/Q
        for (int k = 0; k < 3; k++) begin
            sig_i = 16'($urandom);
            sig_q = 16'($urandom);
            tick();
            chk("reset_hold", {out_i, out_q, out_valid, state, burst_done}, 40'd0);
        end
        reset_b = 1'b1;
        for (int k = 0; k < 20; k++) begin
            sig_i = 16'($urandom);
            sig_q = 16'($urandom);
            tick();
            chk("idle_quiet", {out_i, out_q, out_valid, state, burst_done}, 40'd0);
        end

        // Ramp up to HOLD
        gain      = 16'h4000;
        ramp_step = 16'h1000;
        sig_i     = 16'h1000;
        sig_q     = 16'hF000;
        tx_en     = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("up_state", 40'(state), 40'(UP_ST[k]));
            chk("up_out_i", 40'(out_i), 40'(UP_OI[k]));
            chk("up_out_q", 40'(out_q), 40'(UP_OQ[k]));
            chk("up_valid", 40'(out_valid), 40'(UP_OV[k]));
        end

        // Ramp down to IDLE with a single burst_done pulse
        tx_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("dn_state", 40'(state), 40'(DN_ST[k]));
            chk("dn_out_i", 40'(out_i), 40'(DN_OI[k]));
            chk("dn_done", 40'(burst_done), 40'(DN_BD[k]));
            chk("dn_valid", 40'(out_valid), 40'(DN_OV[k]));
        end

        // Reversal mid-ramp, no burst_done
        for (int k = 0; k < 11; k++) begin
            tx_en = RV_TX[k];
            tick();
            chk("rev_state", 40'(state), 40'(RV_ST[k]));
            chk("rev_out_i", 40'(out_i), 40'(RV_OI[k]));
            chk("rev_done", 40'(burst_done), 40'd0);
        end

        // Return to IDLE
        tx_en = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("ret_state", 40'(state), 40'd0);
        chk("ret_done", 40'(burst_done), 40'd1);
        tick();
        tick();

        // Full-scale gain and step: HOLD after one ramp edge
        gain      = 16'hFFFF;
        ramp_step = 16'hFFFF;
        sig_i     = 16'h7FFF;
        sig_q     = 16'hF000;
        tx_en     = 1'b1;
        tick();
        chk("ovf_state1", 40'(state), 40'd1);
        tick();
        chk("ovf_hold", 40'(state), 40'd2);
        tick();
        tick();
`ifdef TX_RAMP_SAT_EN
        chk("ovf_pos_i", 40'(out_i), 40'h7FFF);
`else
        chk("ovf_pos_i", 40'(out_i), 40'hFFFA);
`endif
        chk("ovf_q", 40'(out_q), 40'hC000);
        sig_i = 16'h8000;
        tick();
        tick();
`ifdef TX_RAMP_SAT_EN
        chk("ovf_neg_i", 40'(out_i), 40'h8000);
`else
        chk("ovf_neg_i", 40'(out_i), 40'h0002);
`endif

        // Single-step ramp-down from 0xFFFF
        tx_en = 1'b0;
        tick();
        chk("big_dn_state", 40'(state), 40'd3);
        tick();
        chk("big_dn_idle", {38'd0, state}, 40'd0);
        chk("big_dn_done", 40'(burst_done), 40'd1);

        // Zero ramp_step behaves as 1: three-edge ramp to gain 3
        gain      = 16'h0003;
        ramp_step = 16'h0000;
        sig_i     = 16'h4000;
        tx_en     = 1'b1;
        tick();
        tick();
        tick();
        chk("step0_ramp3", 40'(state), 40'd1);
        tick();
        chk("step0_hold", 40'(state), 40'd2);
        tick();
        chk("step0_out2", 40'(out_i), 40'd2);
        tick();
        chk("step0_out3", 40'(out_i), 40'd3);

        // Asynchronous reset in HOLD
        #2;
        reset_b = 1'b0;
        #1;
        chk("async_rst", {out_i, out_q, out_valid, state, burst_done}, 40'd0);
        tick();
        chk("rst_held", {out_i, out_q, out_valid, state, burst_done}, 40'd0);
        reset_b = 1'b1;

        // New burst after reset starts from gain 0
        tick();
        chk("post_rst_up", 40'(state), 40'd1);
        tick();
        chk("post_rst_v0", 40'(out_valid), 40'd0);
        tick();
        chk("post_rst_v1", 40'(out_valid), 40'd1);
        chk("post_rst_oi", 40'(out_i), 40'd0);
        tick();
        chk("post_rst_hold", 40'(state), 40'd2);
        tick();
        chk("post_rst_o2", 40'(out_i), 40'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
